control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC CPU.
- Sits directly upstream of the datapath. It consumes IR and the CON flag, and drives every datapath strobe: register select, bus-out, latch enables, memory read/write and ALU opcode.
- Runs fetch (4 steps) and then the per-opcode execute sequence. Each step is one clock.

Parameters:
- ALU_ADD, 5'b00011, ALU opcode driven for address and offset arithmetic.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  asynchronous, active-low reset
- ir  in  32  instruction register contents; opcode = ir[31:27]
- con  in  1  branch-condition flip-flop output from the datapath
- stop  in  1  halt request
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select and enable
- Yin, Zin, Zhighout, Zlowout  out  1 each  Y and Z control
- HIin, HIout, LOin, LOout  out  1 each  HI and LO control
- PCin, PCout, IncPC, IRin  out  1 each  PC and IR control
- MDRin, MDRout, MARin, Read  out  1 each  memory interface registers; Read selects memory into MDR
- memRead, memWrite  out  1 each  RAM read and write enables
- Cout, CONin, InPortOut, OutPortIn  out  1 each  immediate, CON latch and port control
- alu_op  out  5  ALU opcode
- run  out  1  high while executing

Behaviour:
- clear low, at any time including mid-instruction: asynchronously go to RESET. All outputs are 0, including run and alu_op.
- On the first clock edge with clear high, go to F0.
- Outputs are a pure function of the state, plus con in state T7 of br.
- Every strobe not listed for a step is 0.
- alu_op = ir[31:27] in ALU steps and ALU_ADD in address steps. In all other steps alu_op = 0.
- run = 1 in every state except RESET and HALT.
- Fetch:
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, memRead.
  - F2: memRead, Read, MDRin. RAM read latency is one cycle.
  - F3: MDRout, IRin.
  - Decode of ir happens in T4, using the ir value latched in F3.
- Opcodes and execute steps (T4 onward):
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010:
    - T4: Grb, Rout, Yin.
    - T5: Grc, Rout, Zin.
    - T6: Zlowout, Gra, Rin.
  - addi 01011, andi 01100, ori 01101: same as above, except T5 uses Cout instead of Grc+Rout.
  - ldi 00001:
    - T4: Grb, BAout, Yin.
    - T5: Cout, Zin, alu_op = ALU_ADD.
    - T6: Zlowout, Gra, Rin.
  - ld 00000:
    - T4 and T5 as ldi.
    - T6: Zlowout, MARin.
    - T7: memRead.
    - T8: memRead, Read, MDRin.
    - T9: MDRout, Gra, Rin.
  - st 00010:
    - T4 through T6 as ld.
    - T7: Gra, Rout, MDRin, with Read = 0.
    - T8: memWrite.
  - mul 01110, div 01111:
    - T4: Gra, Rout, Yin.
    - T5: Grb, Rout, Zin.
    - T6: Zlowout, LOin.
    - T7: Zhighout, HIin.
  - neg 10000, not 10001:
    - T4: Grb, Rout, Zin.
    - T5: Zlowout, Gra, Rin.
  - br 10010:
    - T4: Gra, Rout, CONin.
    - T5: PCout, Yin.
    - T6: Cout, Zin, alu_op = ALU_ADD.
    - T7: if con = 1, Zlowout and PCin; otherwise no strobes.
  - jr 10011: T4: Gra, Rout, PCin.
  - in 10101: T4: InPortOut, Gra, Rin.
  - out 10110: T4: Gra, Rout, OutPortIn.
  - mfhi 10111: T4: HIout, Gra, Rin.
  - mflo 11000: T4: LOout, Gra, Rin.
  - nop 11001, and all unlisted opcodes: no T4 step; go from F3 directly to F0.
  - halt 11010: go from F3 to HALT.
- End of instruction and halt:
  - The last step of every instruction returns to F0.
  - If stop = 1 when the final step completes, including F3 for nop, go to HALT instead of F0.
  - HALT is sticky: all outputs 0, run = 0. Only clear leaves HALT.
- Instruction lengths in clocks, fetch included:
  - 4: nop.
  - 5: jr, in, out, mfhi, mflo.
  - 6: neg, not.
  - 7: ALU ops, immediate ops, ldi.
  - 8: mul, div, br.
  - 9: st.
  - 10: ld.

Test Plan:
- Release clear → F0 on the next edge. Cycle 1: PCout=MARin=IncPC=Zin=1. Cycle 2: Zlowout=PCin=memRead=1. Cycle 4: IRin=1. run=1 from cycle 1.
- ir=add (0x18000000 | Ra,Rb,Rc fields) → T4 Yin with Grb. T5 Zin with Grc and alu_op=00011. T6 Rin with Gra. Next cycle is F0 (7-cycle instruction).
- ir=ld → T7 memRead alone. T8 memRead, Read, MDRin. T9 MDRout, Rin. Next cycle is F0 (10-cycle instruction).
- br with con=1 → PCin and Zlowout asserted in T7. Repeat with con=0 → T7 has all strobes 0. Both cases return to F0.
- halt opcode → after F3 the FSM stays in HALT for 20+ cycles with run=0 and all outputs 0. Pulse clear low → RESET, then F0.
- Assert clear low asynchronously mid-ld (during T8) → outputs go to 0 immediately, without waiting for a clock edge. Repeat with stop=1 during mul → HALT reached after T7.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini SRC CPU.
// Four fetch steps (F0-F3), then an opcode-dependent execute sequence (T4-T9).
module control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Yin, Zin, Zhighout, Zlowout,
  output logic        HIin, HIout, LOin, LOout,
  output logic        PCin, PCout, IncPC, IRin,
  output logic        MDRin, MDRout, MARin, Read,
  output logic        memRead, memWrite,
  output logic        Cout, CONin, InPortOut, OutPortIn,
  output logic [4:0]  alu_op,
  output logic        run
);
  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01011, OP_ANDI = 5'b01100, OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110, OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000, OP_NOT  = 5'b10001, OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011, OP_IN   = 5'b10101, OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111, OP_MFLO = 5'b11000, OP_HALT = 5'b11010;

  // states: RESET idle after clear | F0-F3 fetch | T4-T9 execute | HALT sticky until clear
  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_F3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_HALT
  } state_t;

  state_t     r_state, w_next, w_last, w_done;
  logic [4:0] w_op;
  logic       w_imm;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_imm       = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
  assign w_unused_ir = ^ir[26:0];
  assign w_done      = stop ? S_HALT : S_F0;

  // Final step of each instruction; S_F3 means no execute phase at all.
  always_comb begin
    w_last = S_F3;
    case (w_op) inside
      OP_LD:                                 w_last = S_T9;
      OP_ST:                                 w_last = S_T8;
      OP_MUL, OP_DIV, OP_BR:                 w_last = S_T7;
      OP_LDI, [5'b00011:5'b01101]:           w_last = S_T6;
      OP_NEG, OP_NOT:                        w_last = S_T5;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: w_last = S_T4;
      default:                               w_last = S_F3;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_F0;
      S_F0:    w_next = S_F1;
      S_F1:    w_next = S_F2;
      S_F2:    w_next = S_F3;
      S_F3: begin
        if (w_op == OP_HALT)     w_next = S_HALT;
        else if (w_last == S_F3) w_next = w_done;
        else                     w_next = S_T4;
      end
      S_T4:    w_next = (w_last == S_T4) ? w_done : S_T5;
      S_T5:    w_next = (w_last == S_T5) ? w_done : S_T6;
      S_T6:    w_next = (w_last == S_T6) ? w_done : S_T7;
      S_T7:    w_next = (w_last == S_T7) ? w_done : S_T8;
      S_T8:    w_next = (w_last == S_T8) ? w_done : S_T9;
      S_T9:    w_next = w_done;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0;
    PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0; IRin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; MARin = 1'b0; Read = 1'b0;
    memRead = 1'b0; memWrite = 1'b0;
    Cout = 1'b0; CONin = 1'b0; InPortOut = 1'b0; OutPortIn = 1'b0;
    alu_op = 5'b00000;
    run = (r_state != S_RESET) && (r_state != S_HALT);
    case (r_state)
      S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_F1: begin Zlowout = 1'b1; PCin = 1'b1; memRead = 1'b1; end
      S_F2: begin memRead = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_F3: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T4, S_T5, S_T6, S_T7, S_T8, S_T9: begin
        case (w_op) inside
          [5'b00011:5'b01101]: begin
            case (r_state)
              S_T4: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T5: begin
                Cout = w_imm; Grc = !w_imm; Rout = !w_imm;
                Zin = 1'b1; alu_op = w_op;
              end
              S_T6: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_LD, OP_LDI, OP_ST: begin
            case (r_state)
              S_T4: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              S_T5: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
              S_T6: begin
                Zlowout = 1'b1;
                if (w_op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                else                MARin = 1'b1;
              end
              S_T7: begin
                if (w_op == OP_LD) memRead = 1'b1;
                else begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
              end
              S_T8: begin
                if (w_op == OP_LD) begin memRead = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                else               memWrite = 1'b1;
              end
              S_T9: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (r_state)
              S_T4: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T5: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op; end
              S_T6: begin Zlowout = 1'b1; LOin = 1'b1; end
              S_T7: begin Zhighout = 1'b1; HIin = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            if (r_state == S_T4) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op; end
            else begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          OP_BR: begin
            case (r_state)
              S_T4: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              S_T5: begin PCout = 1'b1; Yin = 1'b1; end
              S_T6: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
              S_T7: begin Zlowout = con; PCin = con; end
              default: ;
            endcase
          end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_IN:   begin InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction step tables from the sequencing rules, random programs.
module tb_control_unit;
  logic        clock = 1'b0, clear = 1'b1, con = 1'b0, stop = 1'b0;
  logic [31:0] ir = 32'h0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zhighout, Zlowout;
  logic HIin, HIout, LOin, LOout, PCin, PCout, IncPC, IRin;
  logic MDRin, MDRout, MARin, Read, memRead, memWrite;
  logic Cout, CONin, InPortOut, OutPortIn, run;
  logic [4:0]  alu_op;
  logic [33:0] obs;
  int checks = 0, errors = 0;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
    .MDRin(MDRin), .MDRout(MDRout), .MARin(MARin), .Read(Read),
    .memRead(memRead), .memWrite(memWrite),
    .Cout(Cout), .CONin(CONin), .InPortOut(InPortOut), .OutPortIn(OutPortIn),
    .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  assign obs = {run, alu_op, OutPortIn, InPortOut, CONin, Cout, memWrite, memRead, Read, MARin,
                MDRout, MDRin, IRin, IncPC, PCout, PCin, LOout, LOin, HIout, HIin,
                Zlowout, Zhighout, Zin, Yin, BAout, Rout, Rin, Grc, Grb, Gra};

  localparam logic [27:0] GRA = 28'd1 << 0,  GRB = 28'd1 << 1,  GRC = 28'd1 << 2,  RIN = 28'd1 << 3;
  localparam logic [27:0] ROUT = 28'd1 << 4, BAOUT = 28'd1 << 5, YIN = 28'd1 << 6,  ZIN = 28'd1 << 7;
  localparam logic [27:0] ZHI = 28'd1 << 8,  ZLO = 28'd1 << 9,   HIIN = 28'd1 << 10, LOIN = 28'd1 << 12;
  localparam logic [27:0] HIOUT = 28'd1 << 11, LOOUT = 28'd1 << 13, PCIN = 28'd1 << 14, PCOUT = 28'd1 << 15;
  localparam logic [27:0] INCPC = 28'd1 << 16, IRIN = 28'd1 << 17, MDRIN = 28'd1 << 18, MDROUT = 28'd1 << 19;
  localparam logic [27:0] MARIN = 28'd1 << 20, READ = 28'd1 << 21, MRD = 28'd1 << 22, MWR = 28'd1 << 23;
  localparam logic [27:0] COUT = 28'd1 << 24, CONIN = 28'd1 << 25, INP = 28'd1 << 26, OUTP = 28'd1 << 27;

  // Clocks per instruction, fetch included.
  function automatic int instr_len(input logic [4:0] op);
    case (op)
      5'd0:                       return 10;
      5'd2:                       return 9;
      5'd14, 5'd15, 5'd18:        return 8;
      5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13: return 7;
      5'd16, 5'd17:               return 6;
      5'd19, 5'd21, 5'd22, 5'd23, 5'd24: return 5;
      default:                    return 4;
    endcase
  endfunction

  // Expected {run, alu_op, strobes} for step k (0 = F0) of an instruction with opcode op.
  function automatic logic [33:0] exp_out(input logic [4:0] op, input int k, input logic c);
    logic [27:0] m;
    logic [4:0]  a;
    int j;
    m = '0; a = '0; j = k - 4;
    if (k == 0)      m = PCOUT | MARIN | INCPC | ZIN;
    else if (k == 1) m = ZLO | PCIN | MRD;
    else if (k == 2) m = MRD | READ | MDRIN;
    else if (k == 3) m = MDROUT | IRIN;
    else if (op >= 5'd3 && op <= 5'd13) begin
      if (j == 0) m = GRB | ROUT | YIN;
      if (j == 1) begin m = ((op >= 5'd11) ? COUT : (GRC | ROUT)) | ZIN; a = op; end
      if (j == 2) m = ZLO | GRA | RIN;
    end else if (op <= 5'd2) begin
      if (j == 0) m = GRB | BAOUT | YIN;
      if (j == 1) begin m = COUT | ZIN; a = 5'b00011; end
      if (j == 2) m = (op == 5'd1) ? (ZLO | GRA | RIN) : (ZLO | MARIN);
      if (j == 3) m = (op == 5'd0) ? MRD : (GRA | ROUT | MDRIN);
      if (j == 4) m = (op == 5'd0) ? (MRD | READ | MDRIN) : MWR;
      if (j == 5) m = MDROUT | GRA | RIN;
    end else if (op == 5'd14 || op == 5'd15) begin
      if (j == 0) m = GRA | ROUT | YIN;
      if (j == 1) begin m = GRB | ROUT | ZIN; a = op; end
      if (j == 2) m = ZLO | LOIN;
      if (j == 3) m = ZHI | HIIN;
    end else if (op == 5'd16 || op == 5'd17) begin
      if (j == 0) begin m = GRB | ROUT | ZIN; a = op; end
      if (j == 1) m = ZLO | GRA | RIN;
    end else if (op == 5'd18) begin
      if (j == 0) m = GRA | ROUT | CONIN;
      if (j == 1) m = PCOUT | YIN;
      if (j == 2) begin m = COUT | ZIN; a = 5'b00011; end
      if (j == 3) m = c ? (ZLO | PCIN) : '0;
    end else if (op == 5'd19) m = GRA | ROUT | PCIN;
    else if (op == 5'd21) m = INP | GRA | RIN;
    else if (op == 5'd22) m = GRA | ROUT | OUTP;
    else if (op == 5'd23) m = HIOUT | GRA | RIN;
    else if (op == 5'd24) m = LOOUT | GRA | RIN;
    return {1'b1, a, m};
  endfunction

  task automatic check(input logic [33:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with F0 of this instruction about to be sampled next negedge.
  task automatic run_instr(input logic [4:0] op, input logic c, input logic s,
                           input int abort_at, output logic halted);
    int len;
    logic aborted;
    len = instr_len(op);
    aborted = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(negedge clock);
      check(exp_out(op, k, c), $sformatf("op%0d_step%0d_con%0d", op, k, c));
      if (k == 0) begin ir = {op, 27'($urandom)}; con = c; end
      if (k == abort_at) begin aborted = 1'b1; break; end
      stop = (k == len - 1) ? s : 1'($urandom_range(0, 1));
    end
    halted = !aborted && (s || op == 5'd26);
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check(34'h0, $sformatf("halt_cycle%0d", i));
    end
  endtask

  task automatic do_reset();
    #2 clear = 1'b0;
    #1 check(34'h0, "clear_async");
    @(negedge clock);
    check(34'h0, "clear_hold");
    clear = 1'b1;
    stop = 1'b0;
  endtask

  initial begin
    logic h;
    logic [4:0] rop;
    logic rs, rc;
    #1 clear = 1'b0;
    #1 check(34'h0, "reset_async");
    @(negedge clock);
    check(34'h0, "reset_hold");
    clear = 1'b1;

    run_instr(5'd3,  1'b0, 1'b0, -1, h);   // add
    run_instr(5'd0,  1'b0, 1'b0, -1, h);   // ld
    run_instr(5'd18, 1'b1, 1'b0, -1, h);   // br taken
    run_instr(5'd18, 1'b0, 1'b0, -1, h);   // br not taken
    run_instr(5'd14, 1'b0, 1'b1, -1, h);   // mul, stop at end
    check_halt(3);
    do_reset();
    run_instr(5'd26, 1'b0, 1'b0, -1, h);   // halt opcode
    check_halt(22);
    do_reset();
    run_instr(5'd0,  1'b0, 1'b0, 8, h);    // ld aborted during T8
    do_reset();
    run_instr(5'd25, 1'b0, 1'b1, -1, h);   // nop with stop at F3
    check_halt(2);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      rop = 5'($urandom_range(0, 31));
      rs  = ($urandom_range(0, 7) == 0);
      rc  = 1'($urandom_range(0, 1));
      run_instr(rop, rc, rs, -1, h);
      if (h) begin
        check_halt(4);
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
